// File: rtl/bus2reg_arbiter.sv
// Round-robin arbiter giving two bus-side masters shared access to one register-map port.
// One transaction is outstanding at a time; a watchdog answers hung transactions with an error.
module bus2reg_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_req_is_wr,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wr_data,
    input  logic [DATA_WIDTH-1:0] m0_wr_biten,
    output logic                  m0_ready,
    output logic                  m0_err,
    output logic [DATA_WIDTH-1:0] m0_rd_data,
    input  logic                  m1_req,
    input  logic                  m1_req_is_wr,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wr_data,
    input  logic [DATA_WIDTH-1:0] m1_wr_biten,
    output logic                  m1_ready,
    output logic                  m1_err,
    output logic [DATA_WIDTH-1:0] m1_rd_data,
    output logic                  bus_req,
    output logic                  bus_req_is_wr,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wr_data,
    output logic [DATA_WIDTH-1:0] bus_wr_biten,
    output logic                  bus_req_stall_wr,
    output logic                  bus_req_stall_rd,
    input  logic                  bus_ready,
    input  logic                  bus_err,
    input  logic [DATA_WIDTH-1:0] bus_rd_data
);

    localparam int CNT_WIDTH = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t               state;
    state_t               next_state;
    logic                 grant;
    logic                 last_grant;
    logic                 grant_take;
    logic                 grant_sel;
    logic                 resp;
    logic                 timed_out;
    logic [CNT_WIDTH-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        grant_take = 1'b0;
        grant_sel  = grant;
        resp       = 1'b0;
        timed_out  = 1'b0;
        bus_req    = 1'b0;
        m0_ready   = 1'b0;
        m0_err     = 1'b0;
        m0_rd_data = '0;
        m1_ready   = 1'b0;
        m1_err     = 1'b0;
        m1_rd_data = '0;

        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    grant_take = 1'b1;
                    // On contention the master that did not win last time goes next
                    grant_sel  = (m0_req && m1_req) ? ~last_grant : m1_req;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                bus_req    = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                if (bus_ready || bus_err) begin
                    resp       = 1'b1;
                    next_state = IDLE;
                end else if (wait_cnt == CNT_WIDTH'(TIMEOUT)) begin
                    timed_out  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase

        // A timed-out transaction is always an error with zero data
        if (resp || timed_out) begin
            if (grant) begin
                m1_ready   = 1'b1;
                m1_err     = timed_out | bus_err;
                m1_rd_data = (resp && !bus_req_is_wr) ? bus_rd_data : '0;
            end else begin
                m0_ready   = 1'b1;
                m0_err     = timed_out | bus_err;
                m0_rd_data = (resp && !bus_req_is_wr) ? bus_rd_data : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant         <= 1'b0;
            last_grant    <= 1'b1;
            wait_cnt      <= '0;
            bus_req_is_wr <= 1'b0;
            bus_addr      <= '0;
            bus_wr_data   <= '0;
            bus_wr_biten  <= '0;
        end else begin
            if (grant_take) begin
                grant      <= grant_sel;
                last_grant <= grant_sel;
                if (grant_sel) begin
                    bus_req_is_wr <= m1_req_is_wr;
                    bus_addr      <= m1_addr;
                    bus_wr_data   <= m1_wr_data;
                    bus_wr_biten  <= m1_wr_biten;
                end else begin
                    bus_req_is_wr <= m0_req_is_wr;
                    bus_addr      <= m0_addr;
                    bus_wr_data   <= m0_wr_data;
                    bus_wr_biten  <= m0_wr_biten;
                end
            end
            if (state == ISSUE) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign bus_req_stall_wr = (state != IDLE) &&  bus_req_is_wr;
    assign bus_req_stall_rd = (state != IDLE) && !bus_req_is_wr;

endmodule

// File: tb/tb_bus2reg_arbiter.sv
// Scoreboard bench for bus2reg_arbiter: directed transactions push expected bus requests and
// responses into queues; monitor and register-map model processes run independently.
module tb_bus2reg_arbiter;

    localparam int DW = 32;
    localparam int AW = 11;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req      [2];
    logic          is_wr_i  [2];
    logic [AW-1:0] addr_i   [2];
    logic [DW-1:0] wdata_i  [2];
    logic [DW-1:0] biten_i  [2];

    logic          m0_ready, m0_err, m1_ready, m1_err;
    logic [DW-1:0] m0_rd_data, m1_rd_data;
    logic          bus_req, bus_req_is_wr, bus_req_stall_wr, bus_req_stall_rd;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wr_data, bus_wr_biten;
    logic          bus_ready   = 1'b0;
    logic          bus_err     = 1'b0;
    logic [DW-1:0] bus_rd_data = '0;

    typedef struct packed {
        logic          is_wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wr_data;
        logic [DW-1:0] biten;
    } bus_exp_t;

    typedef struct packed {
        logic          master;
        logic          err;
        logic [DW-1:0] rd_data;
    } rsp_exp_t;

    bus_exp_t bus_q[$];
    rsp_exp_t rsp_q[$];

    int   total_count     = 0;
    int   pass_count      = 0;
    int   ready_count     = 0;
    int   bus_req_count   = 0;
    int   stall_rd_cycles = 0;
    int   stall_wr_cycles = 0;
    int   req_age         = 0;
    int   last_ready_age  = 0;
    logic prev_bus_req    = 1'b0;

    logic          rm_silent = 1'b0;
    logic          rm_err    = 1'b0;
    int            rm_delay  = 2;
    logic [AW-1:0] rm_addr;

    bus2reg_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .TIMEOUT   (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .m0_req          (req[0]),
        .m0_req_is_wr    (is_wr_i[0]),
        .m0_addr         (addr_i[0]),
        .m0_wr_data      (wdata_i[0]),
        .m0_wr_biten     (biten_i[0]),
        .m0_ready        (m0_ready),
        .m0_err          (m0_err),
        .m0_rd_data      (m0_rd_data),
        .m1_req          (req[1]),
        .m1_req_is_wr    (is_wr_i[1]),
        .m1_addr         (addr_i[1]),
        .m1_wr_data      (wdata_i[1]),
        .m1_wr_biten     (biten_i[1]),
        .m1_ready        (m1_ready),
        .m1_err          (m1_err),
        .m1_rd_data      (m1_rd_data),
        .bus_req         (bus_req),
        .bus_req_is_wr   (bus_req_is_wr),
        .bus_addr        (bus_addr),
        .bus_wr_data     (bus_wr_data),
        .bus_wr_biten    (bus_wr_biten),
        .bus_req_stall_wr(bus_req_stall_wr),
        .bus_req_stall_rd(bus_req_stall_rd),
        .bus_ready       (bus_ready),
        .bus_err         (bus_err),
        .bus_rd_data     (bus_rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] regmap_data(input logic [AW-1:0] a);
        if (a == 11'h010) return 32'hDEADBEEF;
        return {16'hCAFE, 5'b0, a};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    endtask

    task automatic expect_bus(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] be);
        bus_exp_t e;
        e.is_wr   = wr;
        e.addr    = a;
        e.wr_data = d;
        e.biten   = be;
        bus_q.push_back(e);
    endtask

    task automatic expect_rsp(input logic m, input logic e, input logic [DW-1:0] d);
        rsp_exp_t r;
        r.master  = m;
        r.err     = e;
        r.rd_data = d;
        rsp_q.push_back(r);
    endtask

    // Drives one request and holds it until its ready; keep leaves req high for a follow-on.
    task automatic applyStimulus(input int m, input logic wr, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, input logic [DW-1:0] be, input logic keep);
        logic got;
        got        = 1'b0;
        req[m]     = 1'b1;
        is_wr_i[m] = wr;
        addr_i[m]  = a;
        wdata_i[m] = d;
        biten_i[m] = be;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((m == 0 && m0_ready) || (m == 1 && m1_ready)) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) checkOutput("ready_wait_expired", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        if (!keep) req[m] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset_bus_ctrl", {bus_req, bus_req_is_wr, bus_req_stall_wr, bus_req_stall_rd, bus_addr}, 64'd0);
        checkOutput("reset_bus_data", {bus_wr_data, bus_wr_biten}, 64'd0);
        checkOutput("reset_master_outputs", 64'(|{m0_ready, m0_err, m0_rd_data, m1_ready, m1_err, m1_rd_data}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Bus-side and master-side monitor
    initial begin
        bus_exp_t e;
        rsp_exp_t r;
        forever begin
            @(negedge clk);
            if (bus_req) begin
                bus_req_count++;
                req_age = 0;
                checkOutput("bus_req_single_cycle", 64'(prev_bus_req), 64'd0);
                if (bus_q.size() == 0) begin
                    checkOutput("unexpected_bus_req", 64'd1, 64'd0);
                end else begin
                    e = bus_q.pop_front();
                    checkOutput("bus_is_wr", 64'(bus_req_is_wr), 64'(e.is_wr));
                    checkOutput("bus_addr", 64'(bus_addr), 64'(e.addr));
                    checkOutput("bus_wr_data", 64'(bus_wr_data), 64'(e.wr_data));
                    checkOutput("bus_wr_biten", 64'(bus_wr_biten), 64'(e.biten));
                end
            end else begin
                req_age++;
            end
            prev_bus_req = bus_req;
            if (bus_req_stall_rd) stall_rd_cycles++;
            if (bus_req_stall_wr) stall_wr_cycles++;
            if (m0_ready || m1_ready) begin
                ready_count++;
                last_ready_age = req_age;
                if (m0_ready && m1_ready) begin
                    checkOutput("both_masters_ready", 64'd1, 64'd0);
                end else if (rsp_q.size() == 0) begin
                    checkOutput("unexpected_ready", 64'd1, 64'd0);
                end else begin
                    r = rsp_q.pop_front();
                    checkOutput("rsp_master", 64'(m1_ready), 64'(r.master));
                    checkOutput("rsp_err", 64'(m1_ready ? m1_err : m0_err), 64'(r.err));
                    checkOutput("rsp_rd_data", 64'(m1_ready ? m1_rd_data : m0_rd_data), 64'(r.rd_data));
                    checkOutput("rsp_other_quiet",
                                64'(m1_ready ? |{m0_err, m0_rd_data} : |{m1_err, m1_rd_data}), 64'd0);
                end
            end else begin
                checkOutput("idle_outputs_quiet", 64'(|{m0_err, m1_err, m0_rd_data, m1_rd_data}), 64'd0);
            end
        end
    end

    // Register-map model: answers each bus_req after rm_delay cycles unless silenced
    initial begin
        forever begin
            @(negedge clk);
            if (bus_req && !rm_silent) begin
                rm_addr = bus_addr;
                repeat (rm_delay) @(posedge clk);
                #1;
                bus_ready   = 1'b1;
                bus_err     = rm_err;
                bus_rd_data = regmap_data(rm_addr);
                @(posedge clk);
                #1;
                bus_ready   = 1'b0;
                bus_err     = 1'b0;
                bus_rd_data = '0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_time_limit: actual=expired required=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int s_rd, s_wr, cnt0, rc0;
        logic seen;
        for (int i = 0; i < 2; i++) begin
            req[i]     = 1'b0;
            is_wr_i[i] = 1'b0;
            addr_i[i]  = '0;
            wdata_i[i] = '0;
            biten_i[i] = '0;
        end
        @(posedge clk);
        #1;
        do_reset();

        $display("[TB] single read from m0");
        s_rd = stall_rd_cycles;
        s_wr = stall_wr_cycles;
        expect_bus(1'b0, 11'h010, '0, '0);
        expect_rsp(1'b0, 1'b0, 32'hDEADBEEF);
        applyStimulus(0, 1'b0, 11'h010, '0, '0, 1'b0);
        checkOutput("t1_ready_latency", 64'(last_ready_age), 64'd2);
        checkOutput("t1_stall_rd_cycles", 64'(stall_rd_cycles - s_rd), 64'd3);
        checkOutput("t1_stall_wr_cycles", 64'(stall_wr_cycles - s_wr), 64'd0);

        $display("[TB] write contention after reset");
        do_reset();
        cnt0 = bus_req_count;
        expect_bus(1'b1, 11'h004, 32'h11, 32'hFFFFFFFF);
        expect_bus(1'b1, 11'h008, 32'h22, 32'h0000FFFF);
        expect_rsp(1'b0, 1'b0, '0);
        expect_rsp(1'b1, 1'b0, '0);
        fork
            applyStimulus(0, 1'b1, 11'h004, 32'h11, 32'hFFFFFFFF, 1'b0);
            applyStimulus(1, 1'b1, 11'h008, 32'h22, 32'h0000FFFF, 1'b0);
        join
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t2_bus_req_count", 64'(bus_req_count - cnt0), 64'd2);

        $display("[TB] fairness with continuous reads");
        rm_delay = 1;
        for (int k = 0; k < 3; k++) begin
            expect_bus(1'b0, AW'(11'h100 + k), '0, '0);
            expect_bus(1'b0, AW'(11'h200 + k), '0, '0);
            expect_rsp(1'b0, 1'b0, regmap_data(AW'(11'h100 + k)));
            expect_rsp(1'b1, 1'b0, regmap_data(AW'(11'h200 + k)));
        end
        fork
            begin
                for (int k = 0; k < 3; k++) applyStimulus(0, 1'b0, AW'(11'h100 + k), '0, '0, k < 2);
            end
            begin
                for (int k = 0; k < 3; k++) applyStimulus(1, 1'b0, AW'(11'h200 + k), '0, '0, k < 2);
            end
        join
        checkOutput("t3_fastest_latency", 64'(last_ready_age), 64'd1);

        $display("[TB] error passthrough on m1 write");
        rm_delay = 2;
        rm_err   = 1'b1;
        expect_bus(1'b1, 11'h0AA, 32'h55, 32'hFFFFFFFF);
        expect_rsp(1'b1, 1'b1, '0);
        applyStimulus(1, 1'b1, 11'h0AA, 32'h55, 32'hFFFFFFFF, 1'b0);
        rm_err = 1'b0;

        $display("[TB] watchdog timeout with late response");
        rm_delay = 11;
        expect_bus(1'b0, 11'h020, '0, '0);
        expect_rsp(1'b0, 1'b1, '0);
        applyStimulus(0, 1'b0, 11'h020, '0, '0, 1'b0);
        checkOutput("t5_timeout_latency", 64'(last_ready_age), 64'd9);
        rc0 = ready_count;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("t5_late_response_ignored", 64'(ready_count - rc0), 64'd0);
        rm_delay = 2;

        $display("[TB] reset during outstanding m1 read");
        rm_silent = 1'b1;
        expect_bus(1'b0, 11'h030, '0, '0);
        req[1]     = 1'b1;
        is_wr_i[1] = 1'b0;
        addr_i[1]  = 11'h030;
        wdata_i[1] = '0;
        biten_i[1] = '0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_req) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("t6_bus_req_seen", 64'(seen), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        rm_silent = 1'b0;
        rm_delay  = 1;
        expect_bus(1'b0, 11'h040, '0, '0);
        expect_bus(1'b0, 11'h030, '0, '0);
        expect_rsp(1'b0, 1'b0, regmap_data(11'h040));
        expect_rsp(1'b1, 1'b0, regmap_data(11'h030));
        fork
            applyStimulus(0, 1'b0, 11'h040, '0, '0, 1'b0);
            applyStimulus(1, 1'b0, 11'h030, '0, '0, 1'b0);
            begin
                @(negedge clk);
                checkOutput("t6_outputs_after_reset",
                            64'(|{bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten,
                                  bus_req_stall_wr, bus_req_stall_rd,
                                  m0_ready, m0_err, m0_rd_data, m1_ready, m1_err, m1_rd_data}), 64'd0);
            end
        join

        for (int i = 0; i < 20 && (bus_q.size() != 0 || rsp_q.size() != 0); i++) @(posedge clk);
        checkOutput("bus_queue_drained", 64'(bus_q.size()), 64'd0);
        checkOutput("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
